// File: rtl/cpu_pkg.sv
// Shared core widths and the reorder-buffer entry layout.
package cpu_pkg;

  localparam int unsigned PREG_WIDTH = 6;
  localparam int unsigned AREG_WIDTH = 5;
  localparam int unsigned ROB_DEPTH  = 16;
  localparam int unsigned IDX_WIDTH  = $clog2(ROB_DEPTH);
  localparam int unsigned PTR_WIDTH  = IDX_WIDTH + 1;
  localparam int unsigned PC_WIDTH   = 12;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic                  reg_write;
    logic [AREG_WIDTH-1:0] ard;
    logic [PREG_WIDTH-1:0] prd;
    logic [PREG_WIDTH-1:0] old_prd;
    logic [PC_WIDTH-1:0]   pc;
  } rob_entry_t;

endpackage

// File: rtl/rob_ptr_ctrl.sv
// Head/tail pointers with a wrap bit; derives full, empty and occupancy.
module rob_ptr_ctrl
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_en,
  input  logic                 retire_en,
  output logic [IDX_WIDTH-1:0] head_idx,
  output logic [IDX_WIDTH-1:0] tail_idx,
  output logic                 full,
  output logic                 empty,
  output logic [PTR_WIDTH-1:0] count
);

  logic [PTR_WIDTH-1:0] head;
  logic [PTR_WIDTH-1:0] tail;

  // Advance pointers; the extra MSB toggles on every wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (alloc_en)  tail <= tail + PTR_WIDTH'(1);
      if (retire_en) head <= head + PTR_WIDTH'(1);
    end
  end

  assign head_idx = head[IDX_WIDTH-1:0];
  assign tail_idx = tail[IDX_WIDTH-1:0];
  assign empty    = (head == tail);
  assign full     = (head[IDX_WIDTH-1:0] == tail[IDX_WIDTH-1:0]) &&
                    (head[IDX_WIDTH] != tail[IDX_WIDTH]);
  assign count    = tail - head;

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocate at tail, complete by index, retire from head
// and hand the old physical tag back to the free pool.
module reorder_buffer
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_valid,
  input  logic                  alloc_reg_write,
  input  logic [AREG_WIDTH-1:0] alloc_ard,
  input  logic [PREG_WIDTH-1:0] alloc_prd,
  input  logic [PREG_WIDTH-1:0] alloc_old_prd,
  input  logic [PC_WIDTH-1:0]   alloc_pc,
  output logic                  alloc_ready,
  output logic [IDX_WIDTH-1:0]  alloc_idx,
  input  logic                  complete_valid,
  input  logic [IDX_WIDTH-1:0]  complete_idx,
  output logic                  retire_valid,
  output logic [AREG_WIDTH-1:0] retire_ard,
  output logic [PREG_WIDTH-1:0] retire_prd,
  output logic [PC_WIDTH-1:0]   retire_pc,
  output logic                  rob_push,
  output logic [PREG_WIDTH-1:0] rob_free_reg,
  output logic                  full,
  output logic                  empty,
  output logic [PTR_WIDTH-1:0]  count
);

  rob_entry_t           entries [ROB_DEPTH];
  rob_entry_t           head_entry;
  rob_entry_t           new_entry;
  logic [IDX_WIDTH-1:0] head_idx;
  logic [IDX_WIDTH-1:0] tail_idx;
  logic                 alloc_en;
  logic                 retire_en;

  rob_ptr_ctrl u_ptr (
    .clk       (clk),
    .rst       (rst),
    .alloc_en  (alloc_en),
    .retire_en (retire_en),
    .head_idx  (head_idx),
    .tail_idx  (tail_idx),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // Accept/retire decisions use pre-edge state; an empty ROB has an invalid head.
  always_comb begin
    head_entry           = entries[head_idx];
    alloc_en             = alloc_valid && !full;
    retire_en            = head_entry.valid && head_entry.done;
    new_entry            = '0;
    new_entry.valid      = 1'b1;
    new_entry.done       = 1'b0;
    new_entry.reg_write  = alloc_reg_write;
    new_entry.ard        = alloc_ard;
    new_entry.prd        = alloc_prd;
    new_entry.old_prd    = alloc_old_prd;
    new_entry.pc         = alloc_pc;
  end

  assign alloc_ready = !full;
  assign alloc_idx   = tail_idx;

  // Entry array: completion marks done, retire clears valid, allocation writes the tail.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ROB_DEPTH; i++) entries[i] <= '0;
    end else begin
      if (complete_valid && entries[complete_idx].valid) entries[complete_idx].done <= 1'b1;
      if (retire_en) entries[head_idx].valid <= 1'b0;
      if (alloc_en)  entries[tail_idx] <= new_entry;
    end
  end

  // Registered retire strobe and free-pool push; data holds when idle. Tag 0 is never freed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retire_valid <= 1'b0;
      retire_ard   <= '0;
      retire_prd   <= '0;
      retire_pc    <= '0;
      rob_push     <= 1'b0;
      rob_free_reg <= '0;
    end else begin
      retire_valid <= retire_en;
      rob_push     <= retire_en && head_entry.reg_write && (head_entry.old_prd != '0);
      if (retire_en) begin
        retire_ard   <= head_entry.ard;
        retire_prd   <= head_entry.prd;
        retire_pc    <= head_entry.pc;
        rob_free_reg <= head_entry.old_prd;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer.
module tb_reorder_buffer;

  logic        clk;
  logic        rst;
  logic        alloc_valid;
  logic        alloc_reg_write;
  logic [4:0]  alloc_ard;
  logic [5:0]  alloc_prd;
  logic [5:0]  alloc_old_prd;
  logic [11:0] alloc_pc;
  logic        alloc_ready;
  logic [3:0]  alloc_idx;
  logic        complete_valid;
  logic [3:0]  complete_idx;
  logic        retire_valid;
  logic [4:0]  retire_ard;
  logic [5:0]  retire_prd;
  logic [11:0] retire_pc;
  logic        rob_push;
  logic [5:0]  rob_free_reg;
  logic        full;
  logic        empty;
  logic [4:0]  count;

  int checks = 0;
  int errors = 0;

  reorder_buffer dut (
    .clk             (clk),
    .rst             (rst),
    .alloc_valid     (alloc_valid),
    .alloc_reg_write (alloc_reg_write),
    .alloc_ard       (alloc_ard),
    .alloc_prd       (alloc_prd),
    .alloc_old_prd   (alloc_old_prd),
    .alloc_pc        (alloc_pc),
    .alloc_ready     (alloc_ready),
    .alloc_idx       (alloc_idx),
    .complete_valid  (complete_valid),
    .complete_idx    (complete_idx),
    .retire_valid    (retire_valid),
    .retire_ard      (retire_ard),
    .retire_prd      (retire_prd),
    .retire_pc       (retire_pc),
    .rob_push        (rob_push),
    .rob_free_reg    (rob_free_reg),
    .full            (full),
    .empty           (empty),
    .count           (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    alloc_valid = 0; alloc_reg_write = 0; alloc_ard = '0; alloc_prd = '0;
    alloc_old_prd = '0; alloc_pc = '0; complete_valid = 0; complete_idx = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    #7;
    step();
    rst = 1'b1;
  endtask

  task automatic alloc(input logic rw, input logic [4:0] ard, input logic [5:0] prd,
                       input logic [5:0] old, input logic [11:0] pc);
    alloc_valid = 1; alloc_reg_write = rw; alloc_ard = ard; alloc_prd = prd;
    alloc_old_prd = old; alloc_pc = pc;
    step();
    alloc_valid = 0;
  endtask

  task automatic complete(input logic [3:0] idx);
    complete_valid = 1; complete_idx = idx;
    step();
    complete_valid = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    #2;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b exp 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b exp 0", full); end
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", alloc_ready); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (retire_valid !== 1'b0 || rob_push !== 1'b0 || rob_free_reg !== 6'd0)
      begin errors++; $display("FAIL reset_outputs got rv=%0b push=%0b free=%0d exp 0/0/0", retire_valid, rob_push, rob_free_reg); end
    #5;
    step();
    rst = 1'b1;
  endtask

  task automatic test_in_order();
    do_reset();
    alloc(1, 5'd1, 6'd33, 6'd1, 12'h100);
    alloc(1, 5'd2, 6'd34, 6'd2, 12'h104);
    alloc(1, 5'd3, 6'd35, 6'd3, 12'h108);
    checks++; if (count !== 5'd3) begin errors++; $display("FAIL inorder_count got %0d exp 3", count); end
    for (int i = 0; i < 3; i++) begin
      complete(4'(i));
      checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL inorder_latency%0d got %0b exp 0", i, retire_valid); end
      step();
      checks++; if (retire_valid !== 1'b1) begin errors++; $display("FAIL inorder_rv%0d got %0b exp 1", i, retire_valid); end
      checks++; if (retire_ard !== 5'(i + 1) || retire_prd !== 6'(i + 33) || retire_pc !== 12'(12'h100 + 4 * i))
        begin errors++; $display("FAIL inorder_data%0d got ard=%0d prd=%0d pc=%0h", i, retire_ard, retire_prd, retire_pc); end
      checks++; if (rob_push !== 1'b1 || rob_free_reg !== 6'(i + 1))
        begin errors++; $display("FAIL inorder_free%0d got push=%0b free=%0d exp 1/%0d", i, rob_push, rob_free_reg, i + 1); end
    end
    checks++; if (count !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL inorder_drain got count=%0d empty=%0b exp 0/1", count, empty); end
  endtask

  task automatic test_out_of_order();
    do_reset();
    alloc(1, 5'd4, 6'd40, 6'd10, 12'h200);
    alloc(1, 5'd5, 6'd41, 6'd11, 12'h204);
    complete(4'd1);
    step();
    checks++; if (retire_valid !== 1'b0 || count !== 5'd2)
      begin errors++; $display("FAIL ooo_hold got rv=%0b count=%0d exp 0/2", retire_valid, count); end
    complete(4'd0);
    checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL ooo_latency got %0b exp 0", retire_valid); end
    step();
    checks++; if (retire_valid !== 1'b1 || retire_ard !== 5'd4 || rob_free_reg !== 6'd10)
      begin errors++; $display("FAIL ooo_first got rv=%0b ard=%0d free=%0d exp 1/4/10", retire_valid, retire_ard, rob_free_reg); end
    step();
    checks++; if (retire_valid !== 1'b1 || retire_ard !== 5'd5 || retire_prd !== 6'd41 || rob_free_reg !== 6'd11)
      begin errors++; $display("FAIL ooo_second got rv=%0b ard=%0d prd=%0d free=%0d exp 1/5/41/11", retire_valid, retire_ard, retire_prd, rob_free_reg); end
    step();
    checks++; if (retire_valid !== 1'b0 || rob_push !== 1'b0 || empty !== 1'b1)
      begin errors++; $display("FAIL ooo_idle got rv=%0b push=%0b empty=%0b exp 0/0/1", retire_valid, rob_push, empty); end
  endtask

  task automatic test_full_wrap();
    int n_ret;
    logic [4:0] last_ard;
    logic [5:0] last_free;
    do_reset();
    for (int i = 0; i < 16; i++) alloc(1, 5'(i), 6'(i + 16), 6'(i + 1), 12'(i));
    checks++; if (full !== 1'b1 || alloc_ready !== 1'b0 || count !== 5'd16 || alloc_idx !== 4'd0)
      begin errors++; $display("FAIL full_state got full=%0b ready=%0b count=%0d idx=%0d exp 1/0/16/0", full, alloc_ready, count, alloc_idx); end
    alloc_valid = 1; alloc_reg_write = 1; alloc_ard = 5'd31; alloc_prd = 6'd63; alloc_old_prd = 6'd62; alloc_pc = 12'habc;
    step();
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL full_drop got count=%0d exp 16", count); end
    complete_valid = 1; complete_idx = 4'd0;
    step();
    complete_valid = 0;
    checks++; if (count !== 5'd16 || retire_valid !== 1'b0)
      begin errors++; $display("FAIL full_complete got count=%0d rv=%0b exp 16/0", count, retire_valid); end
    step();
    checks++; if (retire_valid !== 1'b1 || retire_ard !== 5'd0 || rob_free_reg !== 6'd1 || count !== 5'd15 || full !== 1'b0)
      begin errors++; $display("FAIL full_retire got rv=%0b ard=%0d free=%0d count=%0d full=%0b exp 1/0/1/15/0", retire_valid, retire_ard, rob_free_reg, count, full); end
    step();
    alloc_valid = 0;
    checks++; if (count !== 5'd16 || full !== 1'b1 || alloc_idx !== 4'd1)
      begin errors++; $display("FAIL wrap_alloc got count=%0d full=%0b idx=%0d exp 16/1/1", count, full, alloc_idx); end
    n_ret = 0; last_ard = '0; last_free = '0;
    for (int k = 1; k <= 16; k++) begin
      complete_valid = 1; complete_idx = 4'(k);
      step();
      if (retire_valid) begin n_ret++; last_ard = retire_ard; last_free = rob_free_reg; end
    end
    complete_valid = 0;
    for (int c = 0; c < 40; c++) begin
      if (empty) break;
      step();
      if (retire_valid) begin n_ret++; last_ard = retire_ard; last_free = rob_free_reg; end
    end
    checks++; if (n_ret !== 16 || last_ard !== 5'd31 || last_free !== 6'd62 || empty !== 1'b1)
      begin errors++; $display("FAIL wrap_drain got n=%0d ard=%0d free=%0d empty=%0b exp 16/31/62/1", n_ret, last_ard, last_free, empty); end
  endtask

  task automatic test_no_free();
    do_reset();
    alloc(0, 5'd6, 6'd20, 6'd7, 12'h300);
    alloc(1, 5'd7, 6'd21, 6'd0, 12'h304);
    complete(4'd0);
    complete(4'd1);
    checks++; if (retire_valid !== 1'b1 || rob_push !== 1'b0 || retire_ard !== 5'd6)
      begin errors++; $display("FAIL nofree_nowrite got rv=%0b push=%0b ard=%0d exp 1/0/6", retire_valid, rob_push, retire_ard); end
    step();
    checks++; if (retire_valid !== 1'b1 || rob_push !== 1'b0 || retire_ard !== 5'd7 || retire_prd !== 6'd21)
      begin errors++; $display("FAIL nofree_tag0 got rv=%0b push=%0b ard=%0d prd=%0d exp 1/0/7/21", retire_valid, rob_push, retire_ard, retire_prd); end
  endtask

  task automatic test_invalid_complete();
    int n_ret;
    do_reset();
    alloc(1, 5'd1, 6'd40, 6'd21, 12'h400);
    alloc(1, 5'd2, 6'd41, 6'd22, 12'h404);
    complete(4'd5);
    checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL inval_ignored got %0b exp 0", retire_valid); end
    for (int i = 2; i < 5; i++) alloc(1, 5'(i + 1), 6'(i + 40), 6'(i + 21), 12'(i));
    checks++; if (alloc_idx !== 4'd5) begin errors++; $display("FAIL inval_idx got %0d exp 5", alloc_idx); end
    alloc(1, 5'd9, 6'd50, 6'd12, 12'h414);
    n_ret = 0;
    for (int i = 0; i < 5; i++) begin
      complete(4'(i));
      if (retire_valid) n_ret++;
    end
    for (int c = 0; c < 5; c++) begin
      step();
      if (retire_valid) n_ret++;
    end
    checks++; if (n_ret !== 5 || count !== 5'd1 || empty !== 1'b0)
      begin errors++; $display("FAIL inval_stall got n=%0d count=%0d empty=%0b exp 5/1/0", n_ret, count, empty); end
    complete(4'd5);
    checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL inval_latency got %0b exp 0", retire_valid); end
    step();
    checks++; if (retire_valid !== 1'b1 || retire_ard !== 5'd9 || rob_free_reg !== 6'd12 || rob_push !== 1'b1)
      begin errors++; $display("FAIL inval_retire got rv=%0b ard=%0d free=%0d push=%0b exp 1/9/12/1", retire_valid, retire_ard, rob_free_reg, rob_push); end
  endtask

  task automatic test_reset_mid();
    int bad;
    do_reset();
    for (int i = 0; i < 5; i++) alloc(1, 5'(i + 10), 6'(i + 40), 6'(i + 20), 12'(i));
    complete(4'd0);
    step();
    checks++; if (retire_valid !== 1'b1 || rob_push !== 1'b1 || rob_free_reg !== 6'd20 || count !== 5'd4)
      begin errors++; $display("FAIL rstmid_pre got rv=%0b push=%0b free=%0d count=%0d exp 1/1/20/4", retire_valid, rob_push, rob_free_reg, count); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (retire_valid !== 1'b0 || rob_push !== 1'b0 || rob_free_reg !== 6'd0 || retire_ard !== 5'd0)
      begin errors++; $display("FAIL rstmid_async got rv=%0b push=%0b free=%0d ard=%0d exp 0/0/0/0", retire_valid, rob_push, rob_free_reg, retire_ard); end
    checks++; if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0)
      begin errors++; $display("FAIL rstmid_ptr got count=%0d empty=%0b full=%0b exp 0/1/0", count, empty, full); end
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      complete_valid = 1; complete_idx = 4'(1 + (c % 4));
      step();
      if (rob_push || retire_valid) bad++;
    end
    complete_valid = 0;
    checks++; if (bad !== 0 || empty !== 1'b1 || count !== 5'd0)
      begin errors++; $display("FAIL rstmid_after got bad=%0d empty=%0b count=%0d exp 0/1/0", bad, empty, count); end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_out_of_order();
    test_full_wrap();
    test_no_free();
    test_invalid_complete();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- In-order retirement buffer that closes the physical-register loop opened by rename.
- Rename allocates an entry per dispatched instruction, carrying the architectural rd, the new physical tag and the old physical tag.
- Execute marks entries complete by index.
- The head entry retires in program order and returns its old physical tag to the free pool through rob_push / rob_free_reg.

Parameters:
- PREG_WIDTH, 6, physical register tag width.
- AREG_WIDTH, 5, architectural register index width.
- ROB_DEPTH, 16, number of entries; must be a power of 2.
- IDX_WIDTH, 4, log2(ROB_DEPTH).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- alloc_valid  input  1  rename presents an instruction this cycle.
- alloc_reg_write  input  1  instruction writes rd.
- alloc_ard  input  AREG_WIDTH  architectural rd.
- alloc_prd  input  PREG_WIDTH  newly allocated physical tag.
- alloc_old_prd  input  PREG_WIDTH  previous mapping of rd.
- alloc_pc  input  12  instruction PC.
- alloc_ready  output  1  equals !full; an allocation is accepted only when alloc_valid && alloc_ready.
- alloc_idx  output  IDX_WIDTH  current tail index, i.e. the index the presented instruction receives.
- complete_valid  input  1  execute reports completion.
- complete_idx  input  IDX_WIDTH  entry being completed.
- retire_valid  output  1  one-cycle pulse: an entry retired.
- retire_ard  output  AREG_WIDTH  architectural rd of the retired entry.
- retire_prd  output  PREG_WIDTH  committed physical tag.
- retire_pc  output  12  PC of the retired entry.
- rob_push  output  1  push freed tag to the free pool.
- rob_free_reg  output  PREG_WIDTH  tag being freed.
- full  output  1  all entries valid.
- empty  output  1  no entries valid.
- count  output  IDX_WIDTH+1  number of valid entries.

Behaviour:
- Storage: circular array of entries {valid, done, reg_write, ard, prd, old_prd, pc}.
- Pointers: head and tail, each IDX_WIDTH+1 bits, with an extra wrap bit.
  - empty = (head == tail).
  - full = (low bits equal && wrap bits differ).
  - count = tail - head, modulo 2^(IDX_WIDTH+1).
- Reset (asynchronous, rst low):
  - All valid/done bits cleared; head = tail = 0.
  - All registered outputs are 0: retire_*, rob_push, rob_free_reg.
  - empty = 1, full = 0, alloc_ready = 1, count = 0.
  - Reset asserted mid-operation discards all entries; no frees are emitted for them.
- Allocate: on the edge where alloc_valid && !full:
  - Write the entry at tail[IDX-1:0] with valid = 1, done = 0.
  - tail increments and wraps naturally at ROB_DEPTH.
  - When full, alloc_valid is ignored and state is unchanged; rename must hold its instruction.
- Complete: on the edge where complete_valid:
  - If entry[complete_idx].valid, set done = 1.
  - Completion to an invalid entry is ignored.
  - Completion of an already-done entry is a no-op.
  - There is no bypass into an entry being allocated on the same edge.
- Retire (width 1): on an edge where the head entry is valid && done:
  - Clear its valid bit; head increments.
  - Next cycle, retire_valid = 1 with retire_ard, retire_prd and retire_pc from that entry.
  - rob_push = reg_write && (old_prd != 0); rob_free_reg = old_prd. Physical tag 0 is never freed.
  - When nothing retires, retire_valid = 0 and rob_push = 0. Data outputs hold their last value; only the valid and push strobes are meaningful.
- Latency:
  - Completion sampled at edge N makes the entry retire-eligible; it retires at edge N+1.
  - rob_push is visible during the cycle after edge N+1.
  - Complete and retire of the same head entry cannot occur on the same edge.
- Simultaneous allocate and retire:
  - Both take effect; count is unchanged.
  - full/empty are evaluated from pre-edge state, so allocation into a full ROB is refused even if the head retires on that edge.
- Empty ROB: no retire, no push. A complete_valid on an empty ROB is ignored.
- Wrap-around: index ROB_DEPTH-1 is followed by index 0; the wrap bit toggles.

Decomposition:
- Shared package cpu_pkg holds PREG_WIDTH, AREG_WIDTH, ROB_DEPTH, IDX_WIDTH and the rob_entry_t struct.
- rename and free_pool import the same widths from cpu_pkg.
- Natural sub-module: rob_ptr_ctrl, which holds the head/tail pointers and full/empty/count logic.
- The entry array and retire logic remain in reorder_buffer.

Test Plan:
- Reset, then alloc 3 entries {ard=1,prd=33,old=1}, {ard=2,prd=34,old=2}, {ard=3,prd=35,old=3}, complete idx 0,1,2 in order -> three retire pulses in order, rob_free_reg = 1,2,3 with rob_push=1 each; count returns to 0; empty=1.
- Out-of-order completion: alloc idx 0,1; complete idx 1 first -> no retire; then complete idx 0 -> retire idx 0 next edge and idx 1 on the following edge, back-to-back pulses.
- Fill 16 entries -> full=1, alloc_ready=0, count=16; a 17th alloc_valid is dropped. Complete idx 0 while alloc_valid is still held -> after retire, one alloc is accepted at index 0 (wrap), tail wrap bit toggles.
- Non-writing instruction (reg_write=0, old=7) and a writing instruction with old_prd=0 -> retire_valid=1, rob_push=0 for both.
- complete_valid with idx 5 while only idx 0..1 are valid -> ignored; entry 5 is later allocated with done=0 and does not retire until it is completed.
- Assert rst low with 4 entries valid -> outputs 0 immediately (asynchronously); after release, empty=1, count=0, no rob_push ever emitted for the discarded entries.
